// File: rtl/riscv_if.sv
// riscv_if: RV32I instruction-fetch stage.
// Owns the PC, the single-outstanding imem request handshake, a one-entry
// skid buffer for data that lands while decode is stalled, and the IF/ID
// pipeline register.
module riscv_if #(
  parameter int unsigned      XLEN      = 32,
  parameter logic [XLEN-1:0]  RESET_PC  = '0,
  parameter logic [XLEN-1:0]  NOP_INSTR = 'h13
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_if_stall,
  input  logic            i_if_redirect,
  input  logic [XLEN-1:0] i_if_redirect_pc,
  output logic            o_if_imem_req,
  output logic [XLEN-1:0] o_if_imem_addr,
  input  logic            i_if_imem_ack,
  input  logic [XLEN-1:0] i_if_imem_rdata,
  output logic            o_if_valid,
  output logic [XLEN-1:0] o_if_instr,
  output logic [XLEN-1:0] o_if_pc,
  output logic [XLEN-1:0] o_if_pc_plus4
);

  localparam logic [XLEN-1:0] FOUR = XLEN'(4);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DROP,
    S_BUF
  } state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] redir_q, redir_d;
  logic [XLEN-1:0] buf_instr_q, buf_instr_d;
  logic [XLEN-1:0] buf_pc_q, buf_pc_d;
  logic            valid_q, valid_d;
  logic [XLEN-1:0] instr_q, instr_d;
  logic [XLEN-1:0] id_pc_q, id_pc_d;
  logic [XLEN-1:0] id_pc4_q, id_pc4_d;

  logic [XLEN-1:0] redir_tgt;
  logic            new_vld;
  logic [XLEN-1:0] new_instr;
  logic [XLEN-1:0] new_pc;

  // Redirect targets are always word-aligned; the two LSBs are dropped.
  assign redir_tgt = {i_if_redirect_pc[XLEN-1:2], 2'b00};

  logic unused_redir_lsbs;
  assign unused_redir_lsbs = ^i_if_redirect_pc[1:0];

  // Request and address decode purely from the registered state.
  always_comb begin
    o_if_imem_req  = (state_q == S_FETCH) || (state_q == S_DROP);
    o_if_imem_addr = {pc_q[XLEN-1:2], 2'b00};
  end

  // Next-state, PC, skid buffer and IF/ID register update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    redir_d     = redir_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    id_pc_d     = id_pc_q;
    id_pc4_d    = id_pc4_q;
    new_vld     = 1'b0;
    new_instr   = '0;
    new_pc      = '0;

    unique case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
      end
      S_FETCH: begin
        if (i_if_imem_ack) begin
          if (i_if_redirect) begin
            pc_d = redir_tgt;
          end else if (!valid_q || !i_if_stall) begin
            new_vld   = 1'b1;
            new_instr = i_if_imem_rdata;
            new_pc    = pc_q;
            pc_d      = pc_q + FOUR;
          end else begin
            buf_instr_d = i_if_imem_rdata;
            buf_pc_d    = pc_q;
            pc_d        = pc_q + FOUR;
            state_d     = S_BUF;
          end
        end else if (i_if_redirect) begin
          redir_d = redir_tgt;
          state_d = S_DROP;
        end
      end
      S_DROP: begin
        // The abandoned request must still complete before refetching.
        if (i_if_imem_ack) begin
          pc_d    = i_if_redirect ? redir_tgt : redir_q;
          state_d = S_FETCH;
        end else if (i_if_redirect) begin
          redir_d = redir_tgt;
        end
      end
      S_BUF: begin
        if (i_if_redirect) begin
          buf_instr_d = '0;
          buf_pc_d    = '0;
          pc_d        = redir_tgt;
          state_d     = S_FETCH;
        end else if (!i_if_stall) begin
          new_vld   = 1'b1;
          new_instr = buf_instr_q;
          new_pc    = buf_pc_q;
          state_d   = S_FETCH;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // IF/ID: flush beats hold, hold beats load, otherwise insert a bubble.
    if (i_if_redirect) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (i_if_stall && valid_q) begin
      valid_d = valid_q;
    end else if (new_vld) begin
      valid_d  = 1'b1;
      instr_d  = new_instr;
      id_pc_d  = new_pc;
      id_pc4_d = new_pc + FOUR;
    end else begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      redir_q     <= '0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      valid_q     <= 1'b0;
      instr_q     <= NOP_INSTR;
      id_pc_q     <= '0;
      id_pc4_q    <= FOUR;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      redir_q     <= redir_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      valid_q     <= valid_d;
      instr_q     <= instr_d;
      id_pc_q     <= id_pc_d;
      id_pc4_q    <= id_pc4_d;
    end
  end

  assign o_if_valid    = valid_q;
  assign o_if_instr    = instr_q;
  assign o_if_pc       = id_pc_q;
  assign o_if_pc_plus4 = id_pc4_q;

endmodule
